rom_arbiter: RTL and testbench

- Two-requester arbiter/sequencer sharing a single combinational ROM read port (E, addr[3:0], data[7:0]).
- Accepts one read at a time, drives ROM enable/address for one cycle, captures ROM data and returns it to the winning requester.
- Sits between the ROM and two client blocks that would otherwise contend for E/addr.

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_arbiter_pick.sv | 30 +++
 rtl/rom_arbiter.sv | 114 +++++++++++
 tb/tb_rom_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM read-port arbiter.
package rom_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rom_arbiter_pick.sv
// rr_pick2: combinational two-way winner select; with ROM_ARB_FIXED_PRI_EN
// defined, requester 0 always wins and ptr is ignored.
module rr_pick2
   import rom_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic valid,
   output logic winner
);

   assign valid = req0 | req1;

`ifdef ROM_ARB_FIXED_PRI_EN
   logic unused_ptr;
   assign unused_ptr = ptr;
   assign winner = req0 ? REQ0 : REQ1;
`else
   // Only a genuine tie consults the pointer.
   always_comb begin
      winner = REQ0;
      if (req0 && req1)
         winner = ptr;
      else if (req1)
         winner = REQ1;
   end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM port between two requesters.
// Optional macro ROM_ARB_FIXED_PRI_EN selects fixed priority (requester 0).
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rom_e,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   state_t state;
   state_t next_state;
   logic   accept;
   logic   pick_vld;
   logic   pick_win;
   logic   win_p1;
   logic   ptr;

`ifdef ROM_ARB_FIXED_PRI_EN
   assign ptr = REQ0;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= REQ0;
      else if (state == ISSUE)
         ptr <= ~win_p1;
   end
`endif

   rr_pick2 u_pick (
      .req0   (req0),
      .req1   (req1),
      .ptr    (ptr),
      .valid  (pick_vld),
      .winner (pick_win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // ISSUE always lasts one cycle; the rvalid cycle is already IDLE.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               next_state = ISSUE;
               accept     = 1'b1;
            end
         end
         ISSUE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stage p1: grant and ROM address; stage p2: captured data back out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_p1   <= REQ0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
         rom_e    <= 1'b0;
         rom_addr <= '0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         if (accept) begin
            win_p1   <= pick_win;
            rom_e    <= 1'b1;
            rom_addr <= (pick_win == REQ1) ? addr1 : addr0;
            gnt0     <= (pick_win == REQ0);
            gnt1     <= (pick_win == REQ1);
         end
         if (state == ISSUE) begin
            rom_e <= 1'b0;
            if (win_p1 == REQ0) begin
               rdata0  <= rom_data;
               rvalid0 <= 1'b1;
            end else begin
               rdata1  <= rom_data;
               rvalid1 <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter; ROM model returns {4'hA, addr}.
module tb_rom_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0;
   logic [3:0] addr0 = '0;
   logic       gnt0;
   logic       rvalid0;
   logic [7:0] rdata0;
   logic       req1 = 1'b0;
   logic [3:0] addr1 = '0;
   logic       gnt1;
   logic       rvalid1;
   logic [7:0] rdata1;
   logic       rom_e;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rom_data = rom_e ? {4'hA, rom_addr} : 8'h00;

   rom_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .addr0    (addr0),
      .gnt0     (gnt0),
      .rvalid0  (rvalid0),
      .rdata0   (rdata0),
      .req1     (req1),
      .addr1    (addr1),
      .gnt1     (gnt1),
      .rvalid1  (rvalid1),
      .rdata1   (rdata1),
      .rom_e    (rom_e),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_start();
      logic [23:0] got;
      got = {gnt0, gnt1, rvalid0, rvalid1, rom_e, rom_addr, rdata0, rdata1[3:0]};
      total++;
      if (got !== 24'h0 || rdata1 !== 8'h00) begin
         bad++;
         $display("FAIL reset_start: got %h/%h want 0/00", got, rdata1);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_read();
      req0 = 1'b1; addr0 = 4'd3;
      step();
      total++;
      if ({gnt0, gnt1, rom_e, rom_addr} !== {1'b1, 1'b0, 1'b1, 4'd3}) begin
         bad++;
         $display("FAIL single_gnt: got g0=%b g1=%b e=%b a=%h want 1 0 1 3",
                  gnt0, gnt1, rom_e, rom_addr);
      end
      req0 = 1'b0;
      step();
      total++;
      if ({rvalid0, rvalid1, gnt0, rom_e, rom_addr, rdata0} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 8'hA3}) begin
         bad++;
         $display("FAIL single_rvalid: got rv0=%b rv1=%b g0=%b e=%b a=%h d0=%h want 1 0 0 0 3 a3",
                  rvalid0, rvalid1, gnt0, rom_e, rom_addr, rdata0);
      end
      step();
      total++;
      if ({rvalid0, rdata0, rdata1} !== {1'b0, 8'hA3, 8'h00}) begin
         bad++;
         $display("FAIL single_hold: got rv0=%b d0=%h d1=%h want 0 a3 00", rvalid0, rdata0, rdata1);
      end
   endtask

   task automatic test_reset_idle();
      rst = 1'b1;
      #1;
      total++;
      if ({gnt0, gnt1, rvalid0, rvalid1, rom_e, rom_addr, rdata0, rdata1} !== 24'h0) begin
         bad++;
         $display("FAIL reset_idle: got d0=%h d1=%h e=%b a=%h want all zero",
                  rdata0, rdata1, rom_e, rom_addr);
      end
      step();
      rst = 1'b0;
      step();
   endtask

   // Pointer was left at 1 by the single read; reset must put requester 0 first.
   task automatic test_contention();
      logic       id [1:8];
      logic [3:0] exp_flags;
      logic [7:0] exp_data;
      for (int c = 1; c <= 8; c++) begin
`ifdef ROM_ARB_FIXED_PRI_EN
         id[c] = 1'b0;
`else
         id[c] = ((c - 1) / 2) % 2 == 1;
`endif
      end
      req0 = 1'b1; addr0 = 4'd1;
      req1 = 1'b1; addr1 = 4'd2;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c % 2 == 1)
            exp_flags = {id[c] == 1'b0, id[c] == 1'b1, 2'b00};
         else
            exp_flags = {2'b00, id[c-1] == 1'b0, id[c-1] == 1'b1};
         exp_data = (id[c] == 1'b0) ? 8'hA1 : 8'hA2;
         total++;
         if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_flags) begin
            bad++;
            $display("FAIL contention_flags c%0d: got %b want %b", c,
                     {gnt0, gnt1, rvalid0, rvalid1}, exp_flags);
         end
         if (c % 2 == 0) begin
            total++;
            if ((rvalid0 ? rdata0 : rdata1) !== exp_data) begin
               bad++;
               $display("FAIL contention_data c%0d: got %h want %h", c,
                        rvalid0 ? rdata0 : rdata1, exp_data);
            end
         end
      end
      req0 = 1'b0;
      step();
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("FAIL req1_after_drop: got g0=%b g1=%b want 0 1", gnt0, gnt1);
      end
      req1 = 1'b0;
      step();
      total++;
      if ({rvalid0, rvalid1, rdata1} !== {1'b0, 1'b1, 8'hA2}) begin
         bad++;
         $display("FAIL req1_after_drop_data: got rv0=%b rv1=%b d1=%h want 0 1 a2",
                  rvalid0, rvalid1, rdata1);
      end
      step();
   endtask

   task automatic test_reset_mid_issue();
      int rv_seen;
      req0 = 1'b1; addr0 = 4'd4;
      step();
      total++;
      if ({gnt0, rom_e, rom_addr} !== {1'b1, 1'b1, 4'd4}) begin
         bad++;
         $display("FAIL mid_issue_gnt: got g0=%b e=%b a=%h want 1 1 4", gnt0, rom_e, rom_addr);
      end
      req0 = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({gnt0, rom_e} !== 2'b00) begin
         bad++;
         $display("FAIL mid_issue_rst: got g0=%b e=%b want 0 0", gnt0, rom_e);
      end
      step();
      rst = 1'b0;
      rv_seen = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (rvalid0 || gnt0 || rom_e) rv_seen++;
      end
      total++;
      if (rv_seen !== 0) begin
         bad++;
         $display("FAIL mid_issue_quiet: got %0d active cycles want 0", rv_seen);
      end
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      step();
      total++;
      if ({rvalid0, rdata0} !== {1'b1, 8'hA4}) begin
         bad++;
         $display("FAIL mid_issue_retry: got rv0=%b d0=%h want 1 a4", rvalid0, rdata0);
      end
      step();
   endtask

   task automatic test_addr_change();
      req0 = 1'b1; addr0 = 4'd3;
      step();
      addr0 = 4'd0;
      req0 = 1'b0;
      step();
      total++;
      if ({rvalid0, rdata0, rom_addr} !== {1'b1, 8'hA3, 4'd3}) begin
         bad++;
         $display("FAIL addr_change: got rv0=%b d0=%h a=%h want 1 a3 3", rvalid0, rdata0, rom_addr);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int g;
      req1 = 1'b1; addr1 = 4'd7;
      g = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (gnt1) g++;
         total++;
         if (gnt1 !== (c % 2 == 1) || (gnt0 && gnt1) || (rvalid0 && rvalid1)) begin
            bad++;
            $display("FAIL back_to_back c%0d: got g1=%b want %b", c, gnt1, c % 2 == 1);
         end
      end
      req1 = 1'b0;
      step();
      total++;
      if ({rvalid1, rdata1, g} !== {1'b0, 8'hA7, 32'd3}) begin
         bad++;
         $display("FAIL back_to_back_end: got rv1=%b d1=%h grants=%0d want 0 a7 3", rvalid1, rdata1, g);
      end
   endtask

   initial begin
      #1;
      test_reset_start();
      test_single_read();
      test_reset_idle();
      test_contention();
      test_reset_mid_issue();
      test_addr_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
